// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared decode enumerations and opcode constants for the RV32I core
package top_pkg;

    // Decoded operations. CU_ILLEGAL is 0 and the rest keep a fixed order,
    // because this value leaves the core on cuOP.
    typedef enum logic [5:0] {
        CU_ILLEGAL = 6'd0,
        CU_ADD, CU_SUB, CU_AND, CU_OR, CU_XOR, CU_SLL, CU_SRL, CU_SRA, CU_SLT, CU_SLTU,
        CU_ADDI, CU_ANDI, CU_ORI, CU_XORI, CU_SLTI, CU_SLTIU, CU_SLLI, CU_SRLI, CU_SRAI,
        CU_LW, CU_SW, CU_LUI,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
        CU_JAL, CU_JALR
    } cu_op_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Branch compares reuse SUB (equality through zero) and SLT/SLTU
    // (ordering through bit 0 of the result).
    function automatic alu_op_t alu_op_of(input cu_op_t cu);
        case (cu)
            CU_SUB, CU_BEQ, CU_BNE:              alu_op_of = ALU_SUB;
            CU_AND, CU_ANDI:                     alu_op_of = ALU_AND;
            CU_OR,  CU_ORI:                      alu_op_of = ALU_OR;
            CU_XOR, CU_XORI:                     alu_op_of = ALU_XOR;
            CU_SLL, CU_SLLI:                     alu_op_of = ALU_SLL;
            CU_SRL, CU_SRLI:                     alu_op_of = ALU_SRL;
            CU_SRA, CU_SRAI:                     alu_op_of = ALU_SRA;
            CU_SLT, CU_SLTI, CU_BLT, CU_BGE:     alu_op_of = ALU_SLT;
            CU_SLTU, CU_SLTIU, CU_BLTU, CU_BGEU: alu_op_of = ALU_SLTU;
            CU_LUI:                              alu_op_of = ALU_PASSB;
            default:                             alu_op_of = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/top_regfile.sv
// rtl/top_regfile.sv - 32x32 register file, two combinational read ports, one write port
//
// Ports:
//   clk, nrst             rising-edge clock, asynchronous active-low reset (clears all registers)
//   we, waddr, wdata      write port, written on the rising clock edge
//   raddr_a/b, rdata_a/b  combinational read ports; x0 always reads 0
module top_regfile (
    input  logic        clk,
    input  logic        nrst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/top.sv
// rtl/top.sv - single-cycle RV32I core: decoder, immediate generator, ALU, pc, register file
//
// Ports:
//   clk, nrst     rising-edge clock, asynchronous active-low reset
//   instruction   instruction word executed this cycle
//   memload       data-memory read data for LW
//   pc            current program counter (registered)
//   aluIn         ALU operand A (rs1 data)
//   muxOut        ALU operand B (immediate or rs2 data)
//   immOut        sign-extended immediate (0 for R-type and illegal)
//   aluOut        ALU result; zero / negative flags derived from it
//   writeData     register write-back value
//   cuOP          decoded operation (cu_op_t)
// Build option: TOP_BRANCH_EN enables branches, JAL and JALR; without it they
// decode as CU_ILLEGAL.
module top
    import top_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] instruction,
    input  logic [31:0] memload,
    output logic [31:0] pc,
    output logic [31:0] aluIn,
    output logic [31:0] muxOut,
    output logic [31:0] immOut,
    output logic [31:0] aluOut,
    output logic [31:0] writeData,
    output logic        zero,
    output logic        negative,
    output logic [5:0]  cuOP
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd, rs1, rs2;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    cu_op_t cu;

    always_comb begin
        cu = CU_ILLEGAL;
        case (opcode)
            OPC_OP: begin
                case ({funct7, funct3})
                    {7'h00, 3'b000}: cu = CU_ADD;
                    {7'h20, 3'b000}: cu = CU_SUB;
                    {7'h00, 3'b111}: cu = CU_AND;
                    {7'h00, 3'b110}: cu = CU_OR;
                    {7'h00, 3'b100}: cu = CU_XOR;
                    {7'h00, 3'b001}: cu = CU_SLL;
                    {7'h00, 3'b101}: cu = CU_SRL;
                    {7'h20, 3'b101}: cu = CU_SRA;
                    {7'h00, 3'b010}: cu = CU_SLT;
                    {7'h00, 3'b011}: cu = CU_SLTU;
                    default:         cu = CU_ILLEGAL;
                endcase
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000: cu = CU_ADDI;
                    3'b111: cu = CU_ANDI;
                    3'b110: cu = CU_ORI;
                    3'b100: cu = CU_XORI;
                    3'b010: cu = CU_SLTI;
                    3'b011: cu = CU_SLTIU;
                    3'b001: cu = (funct7 == 7'h00) ? CU_SLLI : CU_ILLEGAL;
                    3'b101: begin
                        if (funct7 == 7'h00)      cu = CU_SRLI;
                        else if (funct7 == 7'h20) cu = CU_SRAI;
                        else                      cu = CU_ILLEGAL;
                    end
                    default: cu = CU_ILLEGAL;
                endcase
            end
            OPC_LOAD:  cu = (funct3 == 3'b010) ? CU_LW : CU_ILLEGAL;
            OPC_STORE: cu = (funct3 == 3'b010) ? CU_SW : CU_ILLEGAL;
            OPC_LUI:   cu = CU_LUI;
`ifdef TOP_BRANCH_EN
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  cu = CU_BEQ;
                    3'b001:  cu = CU_BNE;
                    3'b100:  cu = CU_BLT;
                    3'b101:  cu = CU_BGE;
                    3'b110:  cu = CU_BLTU;
                    3'b111:  cu = CU_BGEU;
                    default: cu = CU_ILLEGAL;
                endcase
            end
            OPC_JAL:  cu = CU_JAL;
            OPC_JALR: cu = (funct3 == 3'b000) ? CU_JALR : CU_ILLEGAL;
`endif
            default: cu = CU_ILLEGAL;
        endcase
    end

    assign cuOP = cu;

    // Immediate formats
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'd0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        immOut = 32'd0;
        case (cu)
            CU_ADDI, CU_ANDI, CU_ORI, CU_XORI, CU_SLTI, CU_SLTIU,
            CU_SLLI, CU_SRLI, CU_SRAI, CU_LW, CU_JALR:       immOut = imm_i;
            CU_SW:                                           immOut = imm_s;
            CU_LUI:                                          immOut = imm_u;
            CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU: immOut = imm_b;
            CU_JAL:                                          immOut = imm_j;
            default:                                         immOut = 32'd0;
        endcase
    end

    // Register file
    logic        reg_we;
    logic [31:0] rs2_data;

    top_regfile u_regfile (
        .clk     (clk),
        .nrst    (nrst),
        .we      (reg_we),
        .waddr   (rd),
        .wdata   (writeData),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (aluIn),
        .rdata_b (rs2_data)
    );

    // Operand B: rs2 for register-register ops and compares, the immediate otherwise.
    logic use_rs2;

    always_comb begin
        use_rs2 = 1'b0;
        case (cu)
            CU_ADD, CU_SUB, CU_AND, CU_OR, CU_XOR, CU_SLL, CU_SRL, CU_SRA,
            CU_SLT, CU_SLTU, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
            CU_ILLEGAL: use_rs2 = 1'b1;
            default:    use_rs2 = 1'b0;
        endcase
    end

    assign muxOut = use_rs2 ? rs2_data : immOut;

    // ALU
    alu_op_t alu_op;
    assign alu_op = alu_op_of(cu);

    always_comb begin
        aluOut = 32'd0;
        case (alu_op)
            ALU_ADD:   aluOut = aluIn + muxOut;
            ALU_SUB:   aluOut = aluIn - muxOut;
            ALU_AND:   aluOut = aluIn & muxOut;
            ALU_OR:    aluOut = aluIn | muxOut;
            ALU_XOR:   aluOut = aluIn ^ muxOut;
            ALU_SLL:   aluOut = aluIn << muxOut[4:0];
            ALU_SRL:   aluOut = aluIn >> muxOut[4:0];
            ALU_SRA:   aluOut = $unsigned($signed(aluIn) >>> muxOut[4:0]);
            ALU_SLT:   aluOut = {31'd0, $signed(aluIn) < $signed(muxOut)};
            ALU_SLTU:  aluOut = {31'd0, aluIn < muxOut};
            ALU_PASSB: aluOut = muxOut;
            default:   aluOut = aluIn + muxOut;
        endcase
    end

    assign zero     = (aluOut == 32'd0);
    assign negative = aluOut[31];

    // Write-back
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        writeData = aluOut;
        case (cu)
            CU_LW:           writeData = memload;
            CU_JAL, CU_JALR: writeData = pc_plus4;
            CU_LUI:          writeData = immOut;
            default:         writeData = aluOut;
        endcase
    end

    always_comb begin
        reg_we = 1'b1;
        case (cu)
            CU_ILLEGAL, CU_SW, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU:
                     reg_we = 1'b0;
            default: reg_we = 1'b1;
        endcase
    end

    // Next pc. Branch outcomes read the compare result off the ALU.
    logic        taken;
    logic [31:0] pc_next;

    always_comb begin
        taken = 1'b0;
        case (cu)
            CU_BEQ:  taken = zero;
            CU_BNE:  taken = !zero;
            CU_BLT:  taken = aluOut[0];
            CU_BGE:  taken = !aluOut[0];
            CU_BLTU: taken = aluOut[0];
            CU_BGEU: taken = !aluOut[0];
            CU_JAL:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_plus4;
        if (cu == CU_JALR) begin
            pc_next = {aluOut[31:1], 1'b0};
        end else if (taken) begin
            pc_next = pc + immOut;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc <= 32'd0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed vector bench for top
module tb_top;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] memload = 32'd0;
    logic [31:0] pc, aluIn, muxOut, immOut, aluOut, writeData;
    logic        zero, negative;
    logic [5:0]  cuOP;

    top dut (
        .clk         (clk),
        .nrst        (nrst),
        .instruction (instruction),
        .memload     (memload),
        .pc          (pc),
        .aluIn       (aluIn),
        .muxOut      (muxOut),
        .immOut      (immOut),
        .aluOut      (aluOut),
        .writeData   (writeData),
        .zero        (zero),
        .negative    (negative),
        .cuOP        (cuOP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mem;
        logic [31:0] ain;
        logic [31:0] mux;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [5:0]  cu;
        logic        chk;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one instruction, check its cuOP, clock it, check the resulting pc.
    task automatic step(input string name, input logic [31:0] instr,
                        input logic [5:0] cu, input logic [31:0] pc_after);
        instruction = instr;
        memload = 32'd0;
        #3;
        check({name, " cuOP"}, {26'd0, cuOP}, {26'd0, cu});
        @(posedge clk);
        #1;
        check({name, " pc"}, pc, pc_after);
    endtask

    initial begin
        //                instr          mem           ain           mux           imm           alu           wd        cu  chk
        vecs[0]  = '{32'h3E800093, 32'h0,        32'h0,        32'h3E8,      32'h3E8,      32'h3E8,      32'h3E8,      6'd11, 1'b1};
        vecs[1]  = '{32'h83000113, 32'h0,        32'h0,        32'hFFFFF830, 32'hFFFFF830, 32'hFFFFF830, 32'hFFFFF830, 6'd11, 1'b1};
        vecs[2]  = '{32'h3E906193, 32'h0,        32'h0,        32'h3E9,      32'h3E9,      32'h3E9,      32'h3E9,      6'd13, 1'b1};
        vecs[3]  = '{32'h45707213, 32'h0,        32'h0,        32'h457,      32'h457,      32'h0,        32'h0,        6'd12, 1'b1};
        vecs[4]  = '{32'h3F31F213, 32'h0,        32'h3E9,      32'h3F3,      32'h3F3,      32'h3E1,      32'h3E1,      6'd12, 1'b1};
        vecs[5]  = '{32'h0040A283, 32'hDEADBEEF, 32'h3E8,      32'h4,        32'h4,        32'h3EC,      32'hDEADBEEF, 6'd20, 1'b1};
        vecs[6]  = '{32'h00500013, 32'h0,        32'h0,        32'h5,        32'h5,        32'h5,        32'h5,        6'd11, 1'b1};
        vecs[7]  = '{32'h00208333, 32'h0,        32'h3E8,      32'hFFFFF830, 32'h0,        32'hFFFFFC18, 32'hFFFFFC18, 6'd1,  1'b1};
        vecs[8]  = '{32'h401103B3, 32'h0,        32'hFFFFF830, 32'h3E8,      32'h0,        32'hFFFFF448, 32'hFFFFF448, 6'd2,  1'b1};
        vecs[9]  = '{32'h00112433, 32'h0,        32'hFFFFF830, 32'h3E8,      32'h0,        32'h1,        32'h1,        6'd9,  1'b1};
        vecs[10] = '{32'h001134B3, 32'h0,        32'hFFFFF830, 32'h3E8,      32'h0,        32'h0,        32'h0,        6'd10, 1'b1};
        vecs[11] = '{32'h40415513, 32'h0,        32'hFFFFF830, 32'h404,      32'h404,      32'hFFFFFF83, 32'hFFFFFF83, 6'd19, 1'b1};
        vecs[12] = '{32'h00415593, 32'h0,        32'hFFFFF830, 32'h4,        32'h4,        32'h0FFFFF83, 32'h0FFFFF83, 6'd18, 1'b1};
        vecs[13] = '{32'h12300637, 32'h0,        32'h0,        32'h12300000, 32'h12300000, 32'h12300000, 32'h12300000, 6'd22, 1'b1};
        vecs[14] = '{32'h00112423, 32'h0,        32'hFFFFF830, 32'h8,        32'h8,        32'hFFFFF838, 32'hFFFFF838, 6'd21, 1'b1};
        vecs[15] = '{32'h00040693, 32'h0,        32'h1,        32'h0,        32'h0,        32'h1,        32'h1,        6'd11, 1'b1};
        vecs[16] = '{32'h02208733, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'd0,  1'b0};
        vecs[17] = '{32'h00070793, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'd11, 1'b1};
        vecs[18] = '{32'hFFF14913, 32'h0,        32'hFFFFF830, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000007CF, 32'h000007CF, 6'd14, 1'b1};
        vecs[19] = '{32'hFFF0B993, 32'h0,        32'h3E8,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h1,        6'd16, 1'b1};

        // Reset: pc held at 0 across clock edges.
        instruction = 32'h3E800093;
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", pc, 32'd0);
        check("reset x1", aluIn, 32'd0);
        nrst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            instruction = vecs[i].instr;
            memload = vecs[i].mem;
            #3;
            check($sformatf("v%0d pc", i), pc, 32'(4 * i));
            check($sformatf("v%0d cuOP", i), {26'd0, cuOP}, {26'd0, vecs[i].cu});
            if (vecs[i].chk) begin
                check($sformatf("v%0d aluIn", i), aluIn, vecs[i].ain);
                check($sformatf("v%0d muxOut", i), muxOut, vecs[i].mux);
                check($sformatf("v%0d immOut", i), immOut, vecs[i].imm);
                check($sformatf("v%0d aluOut", i), aluOut, vecs[i].alu);
                check($sformatf("v%0d writeData", i), writeData, vecs[i].wd);
                check($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].alu == 32'd0});
                check($sformatf("v%0d negative", i), {31'd0, negative}, {31'd0, vecs[i].alu[31]});
            end
            @(posedge clk);
            #1;
        end
        check("seq pc", pc, 32'd80);

`ifdef TOP_BRANCH_EN
        instruction = 32'h00000463;
        #3;
        check("beq immOut", immOut, 32'd8);
        step("beq", 32'h00000463, 6'd23, 32'd88);
        step("bne", 32'h00001463, 6'd24, 32'd92);
        step("blt", 32'h00114463, 6'd25, 32'd100);
        step("bltu", 32'h00116463, 6'd27, 32'd104);
        instruction = 32'h0100086F;
        #3;
        check("jal writeData", writeData, 32'd108);
        step("jal", 32'h0100086F, 6'd29, 32'd120);
        instruction = 32'h00180067;
        #3;
        check("jalr aluIn", aluIn, 32'd108);
        step("jalr", 32'h00180067, 6'd30, 32'd108);
`else
        step("beq off", 32'h00000463, 6'd0, 32'd84);
        step("jal off", 32'h0100086F, 6'd0, 32'd88);
        instruction = 32'h00080A13;
        #3;
        check("jal off x16", aluIn, 32'd0);
`endif

        // Reset asserted between edges: pc and registers clear at once.
        instruction = 32'h00008A93;
        #1;
        nrst = 1'b0;
        #1;
        check("async pc", pc, 32'd0);
        check("async x1", aluIn, 32'd0);
        @(posedge clk);
        #1;
        check("held pc", pc, 32'd0);
        nrst = 1'b1;
        instruction = 32'h00700093;
        #3;
        check("restart aluOut", aluOut, 32'd7);
        @(posedge clk);
        #1;
        check("restart pc", pc, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
